// File: rtl/mips_timer_pkg.sv
// Shared definitions for the memory-mapped MIPS timer: register offsets,
// CTRL bit positions, FSM state encoding, mode codes and the byte-lane
// merge used by partial stores.
package mips_timer_pkg;

  // Word offsets on the bridge (DM address bits [3:2])
  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  // CTRL register layout
  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;
  localparam int CTRL_W       = 4;

  // Mode codes; codes 2 and 3 fall back to one-shot behaviour
  localparam logic [1:0] MODE_ONESHOT  = 2'd0;
  localparam logic [1:0] MODE_PERIODIC = 2'd1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  // Replace only the byte lanes whose enable is set
  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  byteen);
    logic [31:0] m;
    m = old_word;
    for (int i = 0; i < 4; i++) begin
      if (byteen[i]) m[8*i +: 8] = new_word[8*i +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/mips_timer.sv
// 32-bit memory-mapped down-counter with one-shot and auto-reload modes.
// Reads are combinational on the bus; writes land at the clock edge.
// irq is the masked interrupt flag and feeds one HWInt line.
module mips_timer
  import mips_timer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  logic [CTRL_W-1:0] ctrl;
  logic [CNT_W-1:0]  preset;
  logic [CNT_W-1:0]  count;
  logic              irq_flag;
  state_t            state;

  logic [31:0] preset_ext;
  logic [31:0] count_ext;
  logic [31:0] reg_word;
  logic [31:0] merged;
  logic        wr_ctrl;
  logic        wr_preset;
  logic        ctrl_en;
  logic        periodic;

  // Zero-extend the counter registers onto the 32-bit bus
  always_comb begin
    preset_ext = '0;
    count_ext  = '0;
    preset_ext[CNT_W-1:0] = preset;
    count_ext[CNT_W-1:0]  = count;
  end

  // Register selected by addr; also the base word for partial stores
  always_comb begin
    reg_word = '0;
    case (addr)
      ADDR_CTRL:   reg_word = {{(32-CTRL_W){1'b0}}, ctrl};
      ADDR_PRESET: reg_word = preset_ext;
      ADDR_COUNT:  reg_word = count_ext;
      default:     reg_word = '0;
    endcase
  end

  assign rdata     = sel ? reg_word : 32'd0;
  assign merged    = byte_merge(reg_word, wdata, byteen);
  assign wr_ctrl   = sel & we & (addr == ADDR_CTRL);
  assign wr_preset = sel & we & (addr == ADDR_PRESET);
  assign ctrl_en   = ctrl[CTRL_EN];
  assign periodic  = (ctrl[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_PERIODIC);
  assign irq       = ctrl[CTRL_IM] & irq_flag;

  // Counter FSM plus CPU register writes; later assignments win, so the
  // CPU CTRL write overrides the FSM clearing EN, and the FSM setting the
  // flag overrides a write-triggered clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrl     <= '0;
      preset   <= '0;
      count    <= '0;
      irq_flag <= 1'b0;
      state    <= IDLE;
    end else begin
      if (wr_ctrl || wr_preset) irq_flag <= 1'b0;

      case (state)
        IDLE: begin
          if (ctrl_en) state <= LOAD;
        end
        LOAD: begin
          count <= preset;
          state <= CNT;
        end
        CNT: begin
          if (!ctrl_en) begin
            state <= IDLE;
          end else if (count != '0) begin
            count <= count - CNT_W'(1);
          end else begin
            irq_flag <= 1'b1;
            state    <= INT;
          end
        end
        INT: begin
          if (periodic) begin
            irq_flag <= 1'b0;
            state    <= LOAD;
          end else begin
            ctrl[CTRL_EN] <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (wr_ctrl)   ctrl   <= merged[CTRL_W-1:0];
      if (wr_preset) preset <= merged[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_mips_timer.sv
// Bench for mips_timer: directed vector table for the timing corner cases,
// then random bus traffic checked against a cycle-level reference model.
module tb_mips_timer;

  logic        clk;
  logic        reset;
  logic        sel;
  logic [1:0]  addr;
  logic        we;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  mips_timer #(.CNT_W(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .sel    (sel),
    .addr   (addr),
    .we     (we),
    .byteen (byteen),
    .wdata  (wdata),
    .rdata  (rdata),
    .irq    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // phase: 0 idle, 1 reload pending, 2 counting, 3 expired
  logic        m_en, m_im;
  logic [1:0]  m_mode;
  logic [31:0] m_preset, m_count;
  logic        m_flag;
  int          m_phase;

  function automatic logic [31:0] m_read(input logic s, input logic [1:0] a);
    if (!s) return 32'd0;
    case (a)
      2'd0:    return {28'd0, m_im, m_mode, m_en};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step(input logic rst, input logic s, input logic w,
                            input logic [1:0] a, input logic [3:0] be,
                            input logic [31:0] wd);
    logic [31:0] nw;
    logic [31:0] lane;
    bit wc, wp;
    if (!rst) begin
      m_en = 0; m_im = 0; m_mode = 0; m_preset = 0; m_count = 0;
      m_flag = 0; m_phase = 0;
      return;
    end
    wc = s && w && (a == 2'd0);
    wp = s && w && (a == 2'd1);
    nw = m_read(1'b1, a);
    for (int b = 0; b < 4; b++) begin
      lane = 32'hFF << (8 * b);
      if (be[b]) nw = (nw & ~lane) | (wd & lane);
    end
    if (wc || wp) m_flag = 0;
    case (m_phase)
      0: if (m_en) m_phase = 1;
      1: begin m_count = m_preset; m_phase = 2; end
      2: begin
        if (!m_en) m_phase = 0;
        else if (m_count > 0) m_count = m_count - 1;
        else begin m_flag = 1; m_phase = 3; end
      end
      default: begin
        if (m_mode == 2'd1) begin m_flag = 0; m_phase = 1; end
        else begin m_en = 0; m_phase = 0; end
      end
    endcase
    if (wc) {m_im, m_mode, m_en} = nw[3:0];
    if (wp) m_preset = nw;
  endtask

  // ---------------- bench plumbing ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One bus cycle: drive, sample at negedge, advance model at posedge
  task automatic cycle(input logic rst, input logic s, input logic w,
                       input logic [1:0] a, input logic [3:0] be, input logic [31:0] wd,
                       output logic [31:0] rd_o, output logic irq_o,
                       output logic [31:0] m_rd, output logic m_irq);
    reset = rst; sel = s; we = w; addr = a; byteen = be; wdata = wd;
    @(negedge clk);
    rd_o  = rdata;
    irq_o = irq;
    m_rd  = m_read(s, a);
    m_irq = m_im & m_flag;
    @(posedge clk);
    model_step(rst, s, w, a, be, wd);
    #1;
  endtask

  typedef struct {
    string       name;
    logic        rst;
    logic        sel;
    logic        we;
    logic [1:0]  addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        chk;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t vq[$];

  task automatic add(input string n, input logic rst, input logic s, input logic w,
                     input logic [1:0] a, input logic [3:0] be, input logic [31:0] wd,
                     input logic c, input logic [31:0] er, input logic ei);
    vec_t v;
    v.name = n; v.rst = rst; v.sel = s; v.we = w; v.addr = a; v.be = be;
    v.wd = wd; v.chk = c; v.exp_rd = er; v.exp_irq = ei;
    vq.push_back(v);
  endtask

  task automatic wr(input string n, input logic [1:0] a, input logic [31:0] wd,
                    input logic [31:0] er, input logic ei);
    add(n, 1'b1, 1'b1, 1'b1, a, 4'hF, wd, 1'b1, er, ei);
  endtask

  task automatic rd(input string n, input logic [1:0] a, input logic [31:0] er, input logic ei);
    add(n, 1'b1, 1'b1, 1'b0, a, 4'h0, 32'd0, 1'b1, er, ei);
  endtask

  task automatic rst_v(input string n);
    add(n, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 32'd0, 1'b0, 32'd0, 1'b0);
  endtask

  initial begin
    logic [31:0] r_rd, m_rd;
    logic        r_irq, m_irq;
    logic        rst_i, s_i, w_i;
    logic [1:0]  a_i;
    logic [3:0]  be_i;
    logic [31:0] wd_i;
    int          r;

    reset = 1'b0; sel = 1'b0; we = 1'b0; addr = 2'd0; byteen = 4'h0; wdata = 32'd0;

    // Reset with random bus activity, then everything reads zero
    for (int i = 0; i < 2; i++)
      cycle(1'b0, 1'($urandom), 1'($urandom), 2'($urandom), 4'($urandom), $urandom,
            r_rd, r_irq, m_rd, m_irq);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 2'(i), 4'h0, 32'd0, r_rd, r_irq, m_rd, m_irq);
      check($sformatf("reset rdata addr%0d", i), r_rd, 32'd0);
      check($sformatf("reset irq addr%0d", i), {31'd0, r_irq}, 32'd0);
    end

    // One-shot, PRESET=3, IM=1
    rst_v("os rst");
    wr("os preset", 2'd1, 32'd3, 32'd0, 1'b0);
    wr("os ctrl", 2'd0, 32'h9, 32'd0, 1'b0);
    rd("os e0", 2'd2, 32'd0, 1'b0);
    rd("os e1", 2'd2, 32'd0, 1'b0);
    rd("os e2", 2'd2, 32'd3, 1'b0);
    rd("os e3", 2'd2, 32'd2, 1'b0);
    rd("os e4", 2'd2, 32'd1, 1'b0);
    rd("os e5", 2'd2, 32'd0, 1'b0);
    rd("os e6", 2'd0, 32'h9, 1'b1);
    rd("os e7", 2'd0, 32'h8, 1'b1);
    rd("os e8", 2'd2, 32'd0, 1'b1);
    wr("os clr", 2'd0, 32'h8, 32'h8, 1'b1);
    rd("os after clr", 2'd0, 32'h8, 1'b0);

    // Periodic, PRESET=2: pulse every 5 cycles
    rst_v("per rst");
    wr("per preset", 2'd1, 32'd2, 32'd0, 1'b0);
    wr("per ctrl", 2'd0, 32'hB, 32'd0, 1'b0);
    rd("per e0", 2'd2, 32'd0, 1'b0);
    rd("per e1", 2'd2, 32'd0, 1'b0);
    rd("per e2", 2'd2, 32'd2, 1'b0);
    rd("per e3", 2'd2, 32'd1, 1'b0);
    rd("per e4", 2'd2, 32'd0, 1'b0);
    rd("per e5", 2'd2, 32'd0, 1'b1);
    rd("per e6", 2'd2, 32'd0, 1'b0);
    rd("per e7", 2'd2, 32'd2, 1'b0);
    rd("per e8", 2'd2, 32'd1, 1'b0);
    rd("per e9", 2'd2, 32'd0, 1'b0);
    rd("per e10", 2'd2, 32'd0, 1'b1);
    rd("per e11", 2'd2, 32'd0, 1'b0);
    rd("per e12", 2'd2, 32'd2, 1'b0);

    // Byte enables and read-only COUNT / reserved slot
    rst_v("be rst");
    wr("be full", 2'd1, 32'h11223344, 32'd0, 1'b0);
    add("be part", 1'b1, 1'b1, 1'b1, 2'd1, 4'b0101, 32'hAABBCCDD, 1'b1, 32'h11223344, 1'b0);
    rd("be merged", 2'd1, 32'h11BB33DD, 1'b0);
    wr("cnt wr", 2'd2, 32'hDEADBEEF, 32'd0, 1'b0);
    rd("cnt ro", 2'd2, 32'd0, 1'b0);
    wr("rsv wr", 2'd3, 32'hFFFFFFFF, 32'd0, 1'b0);
    rd("rsv rd", 2'd3, 32'd0, 1'b0);
    wr("ctrl hi", 2'd0, 32'hFFFFFFF0, 32'd0, 1'b0);
    rd("ctrl hi rd", 2'd0, 32'd0, 1'b0);

    // Masked one-shot: interrupt completes (EN cleared) but irq stays low
    rst_v("im rst");
    wr("im preset", 2'd1, 32'd1, 32'd0, 1'b0);
    wr("im ctrl", 2'd0, 32'h1, 32'd0, 1'b0);
    rd("im e0", 2'd0, 32'h1, 1'b0);
    rd("im e1", 2'd0, 32'h1, 1'b0);
    rd("im e2", 2'd0, 32'h1, 1'b0);
    rd("im e3", 2'd0, 32'h1, 1'b0);
    rd("im e4", 2'd0, 32'h1, 1'b0);
    rd("im e5", 2'd0, 32'h0, 1'b0);
    rd("im e6", 2'd0, 32'h0, 1'b0);

    // Clear EN while COUNT=5: one more decrement, then frozen at 4
    rst_v("ab rst");
    wr("ab preset", 2'd1, 32'd8, 32'd0, 1'b0);
    wr("ab ctrl", 2'd0, 32'h1, 32'd0, 1'b0);
    rd("ab e0", 2'd2, 32'd0, 1'b0);
    rd("ab e1", 2'd2, 32'd0, 1'b0);
    rd("ab e2", 2'd2, 32'd8, 1'b0);
    rd("ab e3", 2'd2, 32'd7, 1'b0);
    rd("ab e4", 2'd2, 32'd6, 1'b0);
    wr("ab stop", 2'd0, 32'h0, 32'h1, 1'b0);
    rd("ab e6", 2'd2, 32'd4, 1'b0);
    rd("ab e7", 2'd2, 32'd4, 1'b0);
    rd("ab e8", 2'd2, 32'd4, 1'b0);

    // Reset while COUNT=7: everything clears, no interrupt later
    rst_v("rm rst");
    wr("rm preset", 2'd1, 32'd10, 32'd0, 1'b0);
    wr("rm ctrl", 2'd0, 32'h9, 32'd0, 1'b0);
    rd("rm e0", 2'd2, 32'd0, 1'b0);
    rd("rm e1", 2'd2, 32'd0, 1'b0);
    rd("rm e2", 2'd2, 32'd10, 1'b0);
    rd("rm e3", 2'd2, 32'd9, 1'b0);
    rd("rm e4", 2'd2, 32'd8, 1'b0);
    add("rm hit", 1'b0, 1'b1, 1'b0, 2'd2, 4'h0, 32'd0, 1'b1, 32'd7, 1'b0);
    rd("rm count", 2'd2, 32'd0, 1'b0);
    rd("rm ctrl0", 2'd0, 32'd0, 1'b0);
    rd("rm preset0", 2'd1, 32'd0, 1'b0);
    for (int i = 0; i < 15; i++)
      add($sformatf("rm quiet%0d", i), 1'b1, 1'b0, 1'b0, 2'd0, 4'h0, 32'd0, 1'b1, 32'd0, 1'b0);

    foreach (vq[i]) begin
      cycle(vq[i].rst, vq[i].sel, vq[i].we, vq[i].addr, vq[i].be, vq[i].wd,
            r_rd, r_irq, m_rd, m_irq);
      if (vq[i].chk) begin
        check({vq[i].name, " rdata"}, r_rd, vq[i].exp_rd);
        check({vq[i].name, " irq"}, {31'd0, r_irq}, {31'd0, vq[i].exp_irq});
      end
    end

    // Random traffic against the reference model
    cycle(1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 32'd0, r_rd, r_irq, m_rd, m_irq);
    for (int n = 0; n < 1500; n++) begin
      r    = int'($urandom_range(0, 99));
      rst_i = 1'b1; s_i = 1'b0; w_i = 1'b0;
      a_i  = 2'($urandom_range(0, 3));
      be_i = 4'($urandom_range(0, 15));
      wd_i = $urandom;
      if (r < 1) begin
        rst_i = 1'b0;
      end else if (r < 7) begin
        s_i = 1'b1; w_i = 1'b1; a_i = 2'd0;
        wd_i[0] = ($urandom_range(0, 3) != 0);
      end else if (r < 11) begin
        s_i = 1'b1; w_i = 1'b1; a_i = 2'd1; be_i = 4'hF;
        wd_i = $urandom_range(0, 9);
      end else if (r < 13) begin
        s_i = 1'b1; w_i = 1'b1; a_i = 2'($urandom_range(2, 3));
      end else if (r < 55) begin
        s_i = 1'b1;
      end else begin
        w_i = 1'($urandom);
      end
      cycle(rst_i, s_i, w_i, a_i, be_i, wd_i, r_rd, r_irq, m_rd, m_irq);
      check($sformatf("rand%0d rdata", n), r_rd, m_rd);
      check($sformatf("rand%0d irq", n), {31'd0, r_irq}, {31'd0, m_irq});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
